// File: rtl/coolgirl_console_pkg.sv
// Shared encodings for the console detection block: FSM states, console_type codes
// and a small constant helper.
package coolgirl_console_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_OBSERVE = 2'd2,
        ST_DONE    = 2'd3
    } det_state_t;

    localparam logic [1:0] CONSOLE_ORIGINAL      = 2'b00;
    localparam logic [1:0] CONSOLE_NEW_FAMICLONE = 2'b01;
    localparam logic [1:0] CONSOLE_UNKNOWN       = 2'b10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer; resets to 1 so active-low strobes read idle.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    localparam int S = (STAGES < 2) ? 2 : STAGES;

    logic [S-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '1;
        else        ff <= {ff[S-2:0], d};
    end

    assign q = ff[S-1];
endmodule

// File: rtl/console_detect.sv
// Classifies the console by grounding CIRAM /CE and /A13, then checking whether the
// /A13 pin follows the inverse of A13 during PPU reads.
module console_detect
    import coolgirl_console_pkg::*;
#(
    parameter int INIT_CYCLES    = 15,
    parameter int SETTLE_CYCLES  = 4,
    parameter int SAMPLES        = 2,
    parameter int MISMATCH_MIN   = 1,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                m2,
    input  logic                                reset_n,
    input  logic                                rearm,
    input  logic                                ppu_rd_in,
    input  logic                                ppu_a13_in,
    input  logic                                ppu_not_a13_in,
    output logic                                ground_en,
    output logic                                detect_done,
    output logic [1:0]                          console_type,
    output logic [$clog2(2*SAMPLES+1)-1:0]      mismatch_cnt
);
    localparam int CW = $clog2(max3(INIT_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam int MW = $clog2(2*SAMPLES + 1);
    localparam int PW = $clog2(SAMPLES + 1);

    localparam logic [CW-1:0] LD_INIT    = CW'(INIT_CYCLES);
    localparam logic [CW-1:0] LD_SETTLE  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] LD_TIMEOUT = CW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] SAMP       = PW'(SAMPLES);
    localparam logic [MW-1:0] MCNT_MAX   = MW'(2*SAMPLES);
    localparam logic [31:0]   MM_MIN     = MISMATCH_MIN;

    logic rd_s, a13_s, na13_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rd   (.clk(m2), .rst_n(reset_n), .d(ppu_rd_in),      .q(rd_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_a13  (.clk(m2), .rst_n(reset_n), .d(ppu_a13_in),     .q(a13_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_na13 (.clk(m2), .rst_n(reset_n), .d(ppu_not_a13_in), .q(na13_s));

    det_state_t    state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] lo_cnt, hi_cnt, lo_nxt, hi_nxt;
    logic [MW-1:0] mcnt_nxt;
    logic          accept, complete;

    // Next-state view of the sample counters lets completion beat a same-edge timeout.
    always_comb begin
        lo_nxt   = lo_cnt;
        hi_nxt   = hi_cnt;
        mcnt_nxt = mismatch_cnt;
        accept   = (state == ST_OBSERVE) && !rd_s &&
                   (a13_s ? (hi_cnt < SAMP) : (lo_cnt < SAMP));
        if (accept) begin
            if (a13_s) hi_nxt = hi_cnt + 1'b1;
            else       lo_nxt = lo_cnt + 1'b1;
            if ((na13_s == a13_s) && (mismatch_cnt < MCNT_MAX))
                mcnt_nxt = mismatch_cnt + 1'b1;
        end
        complete = (lo_nxt == SAMP) && (hi_nxt == SAMP);
    end

    always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_INIT;
            cnt          <= LD_INIT;
            ground_en    <= 1'b1;
            detect_done  <= 1'b0;
            console_type <= CONSOLE_ORIGINAL;
            mismatch_cnt <= '0;
            lo_cnt       <= '0;
            hi_cnt       <= '0;
        end else if (rearm) begin
            state        <= ST_INIT;
            cnt          <= LD_INIT;
            ground_en    <= 1'b1;
            detect_done  <= 1'b0;
            console_type <= CONSOLE_ORIGINAL;
            mismatch_cnt <= '0;
            lo_cnt       <= '0;
            hi_cnt       <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    ground_en <= 1'b1;
                    if (cnt <= CW'(1)) begin
                        state     <= ST_SETTLE;
                        cnt       <= LD_SETTLE;
                        ground_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt <= CW'(1)) begin
                        state        <= ST_OBSERVE;
                        cnt          <= LD_TIMEOUT;
                        lo_cnt       <= '0;
                        hi_cnt       <= '0;
                        mismatch_cnt <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_OBSERVE: begin
                    lo_cnt       <= lo_nxt;
                    hi_cnt       <= hi_nxt;
                    mismatch_cnt <= mcnt_nxt;
                    if (complete) begin
                        state        <= ST_DONE;
                        detect_done  <= 1'b1;
                        console_type <= (32'(mcnt_nxt) >= MM_MIN) ? CONSOLE_NEW_FAMICLONE
                                                                 : CONSOLE_ORIGINAL;
                    end else if (cnt <= CW'(1)) begin
                        state        <= ST_DONE;
                        detect_done  <= 1'b1;
                        console_type <= CONSOLE_UNKNOWN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    detect_done <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/console_detect.md
CONSOLE_DETECT -- requirements
Module: console_detect

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 15: m2 cycles ppu_ciram_ce and ppu_not_a13 are grounded after reset.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: m2 cycles after ground release before sampling.
REQ-003 SHALL have parameter SAMPLES, default 2: accepted reads required per A13 phase (low and high).
REQ-004 SHALL have parameter MISMATCH_MIN, default 1: mismatching samples that classify the console as new famiclone.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535: OBSERVE budget in m2 cycles.
REQ-006 SHALL have parameter SYNC_STAGES, default 2 (min 2): synchronizer depth for PPU inputs.
REQ-007 m2  input  1  the only clock; all state updates on its rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 rearm  input  1  synchronous pulse; restarts detection from INIT.
REQ-010 ppu_rd_in  input  1  PPU read strobe, active-low, asynchronous to m2.
REQ-011 ppu_a13_in  input  1  PPU A13, asynchronous.
REQ-012 ppu_not_a13_in  input  1  sensed level of the /A13 pin, asynchronous.
REQ-013 ground_en  output  1  high: top level drives ppu_ciram_ce and ppu_not_a13 low.
REQ-014 detect_done  output  1  high once a classification is held.
REQ-015 console_type  output  2  00 original, 01 new famiclone, 10 inconclusive, 11 reserved/never driven.
REQ-016 mismatch_cnt  output  clog2(2*SAMPLES+1)  mismatching samples counted in the last OBSERVE.

Function
REQ-017 States SHALL be INIT, SETTLE, OBSERVE, DONE; one shared down-counter of width clog2(max(INIT_CYCLES,SETTLE_CYCLES,TIMEOUT_CYCLES)+1).
REQ-018 INIT: ground_en=1, counter loaded INIT_CYCLES, decrements each m2; at 0 -> SETTLE (ground_en=1 for exactly INIT_CYCLES cycles).
REQ-019 SETTLE: ground_en=0, counts SETTLE_CYCLES; at 0 -> OBSERVE, counter loaded TIMEOUT_CYCLES, sample counters and mismatch_cnt cleared.
REQ-020 OBSERVE: a sample SHALL be accepted on any m2 edge where synchronized ppu_rd is 0 and the phase counter for synchronized a13 is below SAMPLES; extra reads in a saturated phase are ignored.
REQ-021 Accepted sample SHALL be a mismatch when synchronized ppu_not_a13 equals synchronized a13; mismatch_cnt increments, saturating at 2*SAMPLES.
REQ-022 OBSERVE -> DONE when both phase counters equal SAMPLES; console_type=01 if mismatch_cnt >= MISMATCH_MIN else 00.
REQ-023 OBSERVE -> DONE with console_type=10 when counter reaches 0 before both phases complete.
REQ-024 If completion and timeout occur on the same edge, completion SHALL win.
REQ-025 DONE: detect_done=1, console_type and mismatch_cnt held until reset or rearm.
REQ-026 rearm in any state SHALL, on that edge, enter INIT, reload INIT_CYCLES, clear detect_done, console_type and mismatch_cnt; ground_en=1 next cycle.
REQ-027 Samples in the same cycle as rearm SHALL be discarded.
REQ-028 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 reset_n low SHALL asynchronously force state INIT, counter=INIT_CYCLES, ground_en=1, detect_done=0, console_type=00, mismatch_cnt=0, synchronizer flops=1.
REQ-030 Reset deassertion mid-operation SHALL restart full detection; no state survives.

Structure
REQ-031 Package coolgirl_console_pkg SHALL hold state encoding and console_type codes (CONSOLE_ORIGINAL, CONSOLE_NEW_FAMICLONE, CONSOLE_UNKNOWN).
REQ-032 A sub-module sync_bit (SYNC_STAGES-deep, async-reset-to-1) SHALL be instantiated for ppu_rd_in, ppu_a13_in, ppu_not_a13_in.

Verification
REQ-033 Reset, no PPU activity -> ground_en=1 for exactly 15 m2 cycles, detect_done=0 until timeout, then console_type=10 after 15+4+65535 cycles.
REQ-034 Original console: 2 reads a13=0/not_a13=1, 2 reads a13=1/not_a13=0 -> console_type=00, mismatch_cnt=0, detect_done on the edge after the 4th read.
REQ-035 New famiclone: not_a13 stuck 1, 2 reads each phase -> mismatch_cnt=2, console_type=01.
REQ-036 MISMATCH_MIN=3, SAMPLES=4, 2 mismatches -> console_type=00; 3 mismatches -> 01.
REQ-037 rearm asserted in OBSERVE after 3 samples -> ground_en=1 next cycle, mismatch_cnt=0, full 15-cycle INIT repeats.
REQ-038 Final sample and timeout on same edge -> console_type per mismatch rule, never 10.
